// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the APB command arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker with registered last grant
module rr_arb2 (
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] valid_i,
    input  logic       update_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    logic last_grant_q;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        winner_o = (valid_i == 2'b11) ? ~last_grant_q : valid_i[1];
        grant_o  = 2'b00;
        if (valid_i != 2'b00) begin
            grant_o = winner_o ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            last_grant_q <= 1'b1;
        end else if (update_i) begin
            last_grant_q <= winner_o;
        end
    end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// rtl/apb_cmd_arbiter.sv - round-robin sharing of one APB master command port by two requesters
module apb_cmd_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              transfer,
    output logic              READ_WRITE,
    output logic [ADDR_W-1:0] apb_write_paddr,
    output logic [DATA_W-1:0] apb_write_data,
    output logic [ADDR_W-1:0] apb_read_paddr,
    input  logic [DATA_W-1:0] apb_read_data_out,
    input  logic              xfer_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cap_write_q;
    logic              cap_idx_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [1:0] grant;
    logic       winner;
    logic       handshake;
    logic       busy;
    logic       resp;

    rr_arb2 u_rr_arb2 (
        .pclk     (pclk),
        .preset   (preset),
        .valid_i  ({req1_valid, req0_valid}),
        .update_i (handshake),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Ready is forced low during reset so nothing is accepted while held in reset.
    assign req0_ready = ~preset & (state_q == IDLE) & grant[0];
    assign req1_ready = ~preset & (state_q == IDLE) & grant[1];
    assign handshake  = req0_ready | req1_ready;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q     <= BUSY;
                        cnt_q       <= '0;
                        cap_idx_q   <= winner;
                        cap_write_q <= winner ? req1_write : req0_write;
                        cap_addr_q  <= winner ? req1_addr  : req0_addr;
                        cap_wdata_q <= winner ? req1_wdata : req0_wdata;
                    end
                end
                BUSY: begin
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (xfer_done) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        rsp_rdata_q <= cap_write_q ? '0 : apb_read_data_out;
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        cnt_q       <= '0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    assign transfer        = busy;
    assign READ_WRITE      = busy & (cap_write_q ? RW_WRITE : RW_READ);
    assign apb_write_paddr = (busy &  cap_write_q) ? cap_addr_q  : '0;
    assign apb_write_data  = (busy &  cap_write_q) ? cap_wdata_q : '0;
    assign apb_read_paddr  = (busy & ~cap_write_q) ? cap_addr_q  : '0;

    assign rsp0_valid = resp & ~cap_idx_q;
    assign rsp1_valid = resp &  cap_idx_q;
    assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
    assign rsp0_err   = rsp0_valid & rsp_err_q;
    assign rsp1_err   = rsp1_valid & rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// tb/tb_apb_cmd_arbiter.sv - directed bench with a transaction-level reference model
module tb_apb_cmd_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset = 1'b0;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic [DW-1:0] apb_read_data_out = '0;
    logic          xfer_done = 1'b0;

    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata, apb_write_data;
    logic          transfer, READ_WRITE;
    logic [AW-1:0] apb_write_paddr, apb_read_paddr;

    apb_cmd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk              (pclk),
        .preset            (preset),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req0_write        (req0_write),
        .req0_addr         (req0_addr),
        .req0_wdata        (req0_wdata),
        .rsp0_valid        (rsp0_valid),
        .rsp0_rdata        (rsp0_rdata),
        .rsp0_err          (rsp0_err),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .req1_write        (req1_write),
        .req1_addr         (req1_addr),
        .req1_wdata        (req1_wdata),
        .rsp1_valid        (rsp1_valid),
        .rsp1_rdata        (rsp1_rdata),
        .rsp1_err          (rsp1_err),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .xfer_done         (xfer_done)
    );

    always #5 pclk = ~pclk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who holds the master, for how long, and what it will answer.
    bit        m_busy, m_answer, m_wr, m_owner, m_err;
    bit        m_last = 1'b1;
    logic [7:0] m_addr, m_wdata, m_rdata;
    int        m_age;

    task automatic model_reset();
        m_busy = 0; m_answer = 0; m_wr = 0; m_owner = 0; m_err = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_age = 0;
    endtask

    int grant_log[$], grant_cyc[$], rsp_log[$], run_log[$], bus_log[$];
    int run = 0;
    int cyc = 0;

    task automatic clr_logs();
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
        run_log.delete(); bus_log.delete(); run = 0;
    endtask

    initial begin : compare_proc
        bit win, free, e_rdy0, e_rdy1;
        logic [31:0] e_bus, e_rsp0, e_rsp1;
        forever begin
            @(negedge pclk);
            #2;
            if (preset) model_reset();
            win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            free = !m_busy && !m_answer;
            e_rdy0 = !preset && free && req0_valid && !win;
            e_rdy1 = !preset && free && req1_valid && win;
            e_bus = 32'h0;
            if (m_busy) e_bus = m_wr ? {8'h00, m_addr, m_wdata, 8'h00} : {8'h01, 16'h0000, m_addr};
            e_rsp0 = (m_answer && !m_owner) ? {15'b0, 1'b1, m_rdata, 7'b0, m_err} : 32'h0;
            e_rsp1 = (m_answer &&  m_owner) ? {15'b0, 1'b1, m_rdata, 7'b0, m_err} : 32'h0;
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_rdy0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_rdy1});
            chk("transfer", {31'b0, transfer}, {31'b0, m_busy});
            chk("cmd_bus", {7'b0, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr}, e_bus);
            chk("rsp0", {15'b0, rsp0_valid, rsp0_rdata, 7'b0, rsp0_err}, e_rsp0);
            chk("rsp1", {15'b0, rsp1_valid, rsp1_rdata, 7'b0, rsp1_err}, e_rsp1);

            if (req0_ready) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
            if (req1_ready) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
            if (rsp0_valid) rsp_log.push_back((int'(rsp0_rdata) << 8) | int'(rsp0_err));
            if (rsp1_valid) rsp_log.push_back(32'h10000 | (int'(rsp1_rdata) << 8) | int'(rsp1_err));
            if (transfer) begin
                if (run == 0)
                    bus_log.push_back({7'b0, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr});
                run++;
            end else if (run > 0) begin
                run_log.push_back(run);
                run = 0;
            end
            cyc++;

            @(posedge pclk);
            if (preset) begin
                model_reset();
            end else if (m_answer) begin
                m_answer = 0;
            end else if (m_busy) begin
                if (xfer_done) begin
                    m_busy = 0; m_answer = 1; m_err = 0;
                    m_rdata = m_wr ? 8'h00 : apb_read_data_out;
                end else if (m_age + 1 == TO) begin
                    m_busy = 0; m_answer = 1; m_err = 1; m_rdata = 8'h00;
                end else begin
                    m_age++;
                end
            end else if (req0_valid || req1_valid) begin
                win = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_owner = win; m_last = win; m_busy = 1; m_age = 0;
                m_wr    = win ? req1_write : req0_write;
                m_addr  = win ? req1_addr  : req0_addr;
                m_wdata = win ? req1_wdata : req0_wdata;
            end
        end
    end

    // Requesters issue left0/left1 commands; the master answers done_delay cycles into a transfer.
    int left0 = 0, left1 = 0;
    int done_delay = -1;
    int bcnt = 0;
    bit idle_pulse = 0;

    task automatic tick();
        req0_valid = (left0 > 0);
        req1_valid = (left1 > 0);
        if (transfer) begin
            xfer_done = (bcnt == done_delay);
            bcnt++;
        end else begin
            xfer_done = idle_pulse;
            bcnt = 0;
        end
        idle_pulse = 0;
        #3;
        if (req0_ready) left0--;
        if (req1_ready) left1--;
        @(negedge pclk);
    endtask

    initial begin : stimulus
        #1 preset = 1'b1;
        @(negedge pclk);
        tick(); tick();
        chk("reset_outputs", {26'b0, transfer, READ_WRITE, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 32'h0);
        preset = 1'b0;

        // write from requester 0
        clr_logs();
        req0_write = 1'b1; req0_addr = 8'h12; req0_wdata = 8'hA5;
        done_delay = 2; left0 = 1;
        repeat (8) tick();
        chk("t1_grants", grant_log.size(), 1);
        chk("t1_grant0", grant_log[0], 0);
        chk("t1_bus", bus_log[0], 32'h0012A500);
        chk("t1_run", run_log[0], 3);
        chk("t1_nrsp", rsp_log.size(), 1);
        chk("t1_rsp", rsp_log[0], 32'h0);

        // read from requester 1
        clr_logs();
        req1_write = 1'b0; req1_addr = 8'h40; apb_read_data_out = 8'h3C;
        done_delay = 0; left1 = 1;
        repeat (6) tick();
        chk("t2_bus", bus_log[0], 32'h01000040);
        chk("t2_nrsp", rsp_log.size(), 1);
        chk("t2_rsp", rsp_log[0], 32'h00013C00);

        // both requesters continuously valid
        clr_logs();
        left0 = 4; left1 = 4;
        repeat (30) tick();
        chk("t3_grants", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        chk("t3_span", grant_cyc[7] - grant_cyc[0], 21);
        chk("t3_runs", run_log.size(), 8);

        // timeout on a read, then a queued write from requester 1
        clr_logs();
        req0_write = 1'b0; req0_addr = 8'h55; done_delay = -1; left0 = 1;
        tick();
        req1_write = 1'b1; req1_addr = 8'h66; req1_wdata = 8'h11; left1 = 1;
        repeat (9) tick();
        done_delay = 0;
        repeat (15) tick();
        chk("t4_run", run_log[0], 16);
        chk("t4_rsp_err", rsp_log[0], 32'h00000001);
        chk("t4_rsp_next", rsp_log[1], 32'h00010000);
        chk("t4_grant_next", grant_log[1], 1);

        // completion on the last allowed cycle, and a stray done while idle
        clr_logs();
        idle_pulse = 1;
        tick(); tick();
        chk("t5_idle_rsp", rsp_log.size(), 0);
        chk("t5_idle_grant", grant_log.size(), 0);
        req1_write = 1'b0; req1_addr = 8'h77; apb_read_data_out = 8'h9E;
        done_delay = 15; left1 = 1;
        repeat (22) tick();
        chk("t5_run", run_log[0], 16);
        chk("t5_rsp", rsp_log[0], 32'h00019E00);

        // reset in the middle of a transfer
        req0_write = 1'b1; req0_addr = 8'h21; req0_wdata = 8'h43;
        done_delay = -1; left0 = 1;
        repeat (6) tick();
        clr_logs();
        preset = 1'b1;
        tick();
        chk("t6_rst_transfer", {31'b0, transfer}, 32'h0);
        left0 = 1; left1 = 1;
        tick();
        chk("t6_rst_norsp", rsp_log.size(), 0);
        chk("t6_rst_nogrant", grant_log.size(), 0);
        preset = 1'b0; done_delay = 0;
        repeat (10) tick();
        chk("t6_first", grant_log[0], 0);
        chk("t6_second", grant_log[1], 1);
        chk("t6_nrsp", rsp_log.size(), 2);
        chk("t6_rsp0", rsp_log[0], 32'h0);
        chk("t6_rsp1", rsp_log[1], 32'h00019E00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
